// File: rtl/kronecker_pkg.sv
// Shared widths and field offsets for the Kronecker-delta sequencer and its result FIFO.
package kronecker_pkg;
  localparam int KR_LAT  = 3;
  localparam int SHARE_W = 8;
  localparam int RAND_W  = 4;
  localparam int DATA_W  = 2 * SHARE_W;
  localparam int Z_W     = 2;
  localparam int SH0_LSB = 0;
  localparam int SH1_LSB = SHARE_W;

  typedef logic [Z_W-1:0] z_t;
endpackage

// File: rtl/kronecker_res_fifo.sv
// DEPTH x 2-bit result FIFO; each share lane of Z lives in its own register array.
module kronecker_res_fifo
  import kronecker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [Z_W-1:0] wr_data,
  input  logic           rd_en,
  output logic [Z_W-1:0] rd_data,
  output logic           full,
  output logic           empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_rd;

  assign w_rd  = rd_en && !empty;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

  // Lanes are kept apart so the two result shares never share a storage cell.
  genvar gi;
  generate
    for (gi = 0; gi < Z_W; gi++) begin : g_lane
      logic [DEPTH-1:0] r_lane;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_lane <= '0;
        else if (wr_en) r_lane[r_wr_ptr] <= wr_data[gi];
      end
      assign rd_data[gi] = r_lane[r_rd_ptr];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({wr_en, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/kronecker_sched.sv
// Feeds masked bytes plus fresh randomness into the fixed-latency Kronecker datapath
// and buffers its shared results behind an occupancy credit so nothing is dropped.
module kronecker_sched
  import kronecker_pkg::*;
#(
  parameter int LAT   = KR_LAT,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  input  logic [RAND_W-1:0] rnd_data,
  output logic [DATA_W-1:0] dp_inp,
  output logic [RAND_W-1:0] dp_rand,
  input  logic [Z_W-1:0]    dp_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Z_W-1:0]    out_data,
  output logic              busy
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]      r_occ;
  logic [LAT:0]       r_vld;
  logic [DATA_W-1:0]  r_dp_inp;
  logic [RAND_W-1:0]  r_dp_rand;
  logic               w_accept;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [SHARE_W-1:0] w_sh0_gated;
  logic [SHARE_W-1:0] w_sh1_gated;
  logic [RAND_W-1:0]  w_rnd_gated;

  // Credit uses the registered occupancy only; a same-cycle pop does not free a slot.
  assign in_ready  = rnd_valid && (r_occ < CW'(DEPTH));
  assign w_accept  = in_valid && in_ready;
  assign rnd_ready = w_accept;
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign busy      = (r_occ != '0);
  assign dp_inp    = r_dp_inp;
  assign dp_rand   = r_dp_rand;

  // Bubbles zero each share bit individually; no gate ever sees both shares.
  genvar gi;
  generate
    for (gi = 0; gi < SHARE_W; gi++) begin : g_share_gate
      assign w_sh0_gated[gi] = in_data[SH0_LSB + gi] & w_accept;
      assign w_sh1_gated[gi] = in_data[SH1_LSB + gi] & w_accept;
    end
    for (gi = 0; gi < RAND_W; gi++) begin : g_rand_gate
      assign w_rnd_gated[gi] = rnd_data[gi] & w_accept;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_inp  <= '0;
      r_dp_rand <= '0;
      r_vld     <= '0;
      r_occ     <= '0;
    end else begin
      r_dp_inp  <= {w_sh1_gated, w_sh0_gated};
      r_dp_rand <= w_rnd_gated;
      r_vld     <= {r_vld[LAT-1:0], w_accept};
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  kronecker_res_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (r_vld[LAT]),
    .wr_data(dp_z),
    .rd_en  (w_pop),
    .rd_data(out_data),
    .full   (w_full),
    .empty  (w_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_vld[LAT] && w_full && !w_pop));
endmodule

// File: tb/tb_kronecker_sched.sv
// Directed-plus-random bench for kronecker_sched with a queue-based reference model.
module tb_kronecker_sched;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready, busy;
  logic [15:0] in_data, dp_inp;
  logic [3:0]  rnd_data, dp_rand;
  logic [1:0]  dp_z, out_data;
  logic [1:0]  z_pipe [LAT];

  int cmp  = 0;
  int mism = 0;
  int cyc  = 0;
  int occ_m = 0;
  logic [15:0] fl_data[$];
  int          fl_due[$];
  logic [1:0]  buf_q[$];

  always #5 clk = ~clk;

  kronecker_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
    .dp_inp(dp_inp), .dp_rand(dp_rand), .dp_z(dp_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  // Datapath stub: per-share parity, LAT register stages.
  always_ff @(posedge clk) begin
    z_pipe[0] <= {^dp_inp[15:8], ^dp_inp[7:0]};
    for (int i = 1; i < LAT; i++) z_pipe[i] <= z_pipe[i-1];
  end
  assign dp_z = z_pipe[LAT-1];

  function automatic logic [1:0] kron(input logic [15:0] d);
    return {^d[15:8], ^d[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic iv, input logic [15:0] d, input logic rv,
                      input logic [3:0] r, input logic ordy);
    logic exp_rdy, acc, pop;
    in_valid = iv; in_data = d; rnd_valid = rv; rnd_data = r; out_ready = ordy;
    #1;
    exp_rdy = rv && (occ_m < DEPTH);
    acc     = iv && exp_rdy;
    pop     = ordy && (buf_q.size() > 0);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("rnd_ready", 32'(rnd_ready), 32'(acc));
    chk("out_valid", 32'(out_valid), 32'(buf_q.size() > 0));
    if (buf_q.size() > 0) chk("out_data", 32'(out_data), 32'(buf_q[0]));
    chk("busy", 32'(busy), 32'(occ_m != 0));
    chk("occ", 32'(dut.r_occ), 32'(occ_m));
    @(posedge clk);
    cyc++;
    if (pop) begin
      $display("cyc %0d pop z=%b", cyc, buf_q[0]);
      void'(buf_q.pop_front());
      occ_m--;
    end
    if (acc) begin
      $display("cyc %0d accept data=%h rnd=%h", cyc, d, r);
      fl_data.push_back(d);
      fl_due.push_back(cyc + LAT + 1);
      occ_m++;
    end
    while (fl_due.size() > 0 && fl_due[0] <= cyc) begin
      buf_q.push_back(kron(fl_data[0]));
      void'(fl_data.pop_front());
      void'(fl_due.pop_front());
    end
    #1;
    chk("dp_inp", 32'(dp_inp), acc ? 32'(d) : 32'd0);
    chk("dp_rand", 32'(dp_rand), acc ? 32'(r) : 32'd0);
  endtask

  task automatic rnd_item(input logic ordy);
    step(1'b1, 16'($urandom), 1'b1, 4'($urandom), ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && (occ_m > 0); i++) step(1'b0, 16'h0, 1'b1, 4'h0, 1'b1);
    chk("drained", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_data = 0; rnd_valid = 0; rnd_data = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dp_inp", 32'(dp_inp), 32'd0);
    chk("rst_dp_rand", 32'(dp_rand), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); cyc++; #1;

    // Single item, latency LAT+1 to out_valid.
    step(1'b1, 16'h01FF, 1'b1, 4'hA, 1'b0);
    chk("single_dp_inp", 32'(dp_inp), 32'h01FF);
    chk("single_dp_rand", 32'(dp_rand), 32'hA);
    for (int i = 0; i < LAT; i++) step(1'b0, 16'h0, 1'b1, 4'h0, 1'b0);
    chk("single_not_yet", 32'(out_valid), 32'd0);
    step(1'b0, 16'h0, 1'b1, 4'h0, 1'b0);
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data", 32'(out_data), 32'h2);
    step(1'b0, 16'h0, 1'b1, 4'h0, 1'b1);
    chk("single_busy_after_pop", 32'(busy), 32'd0);

    // Randomness starvation, then accept once randomness returns.
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b0, 4'($urandom), 1'b1);
    rnd_item(1'b1);
    drain();

    // Backpressure: only DEPTH accepted, drained in order, then accepts resume.
    for (int i = 0; i < 6; i++) rnd_item(1'b0);
    for (int i = 0; i < LAT + 2; i++) step(1'b1, 16'($urandom), 1'b1, 4'($urandom), 1'b0);
    chk("bp_full_occ", 32'(dut.r_occ), 32'd4);
    for (int i = 0; i < 8; i++) rnd_item(1'b1);
    drain();

    // Streaming back-to-back.
    for (int i = 0; i < 16; i++) rnd_item(1'b1);
    drain();

    // Pop and accept together at occ = DEPTH-1.
    for (int i = 0; i < 3; i++) rnd_item(1'b0);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 16'h0, 1'b1, 4'h0, 1'b0);
    rnd_item(1'b1);
    chk("pop_acc_occ", 32'(dut.r_occ), 32'd3);
    chk("pop_acc_ready", 32'(in_ready), 32'd1);
    drain();

    // Reset with one buffered and two in-flight items.
    rnd_item(1'b0);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 16'h0, 1'b1, 4'h0, 1'b0);
    rnd_item(1'b0);
    rnd_item(1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dp_inp", 32'(dp_inp), 32'd0);
    fl_data.delete(); fl_due.delete(); buf_q.delete(); occ_m = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); cyc++; #1;
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1, 4'h0, 1'b1);
    rnd_item(1'b1);
    drain();

    // Random traffic.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 4) != 0),
           4'($urandom), 1'($urandom_range(0, 2) != 0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
